// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller.
// State encoding, default ISR layout and the fixed-priority encoder.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [15:0] DEF_ISR_BASE   = 16'h0040;
    localparam int          DEF_ISR_STRIDE = 4;
    localparam int          MAX_IRQ        = 16;
    localparam int          MAX_VEC_W      = 4;

    // Lowest set index wins; zero input returns zero.
    function automatic logic [MAX_VEC_W-1:0] prio_enc(
        input logic [MAX_IRQ-1:0] v
    );
        prio_enc = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = MAX_VEC_W'(i);
        end
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Sequencer <-> interrupt controller bundle.
// master = sequencer/data path side, slave = controller side.
interface interrupt_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3,
    parameter int ADDR_W  = 16
) ();
    logic [NUM_IRQ-1:0] irqIn;
    logic [NUM_IRQ-1:0] maskIn;
    logic               MASKld;
    logic               MASKclr;
    logic               intDisable;
    logic               intEnable;
    logic               clrPend;
    logic               eoi;
    logic               intPending;
    logic [VEC_W-1:0]   intVector;
    logic [ADDR_W-1:0]  isrAddr;
    logic               inService;
    logic [NUM_IRQ-1:0] pendBits;
    logic [NUM_IRQ-1:0] maskBits;

    modport master (
        output irqIn, maskIn, MASKld, MASKclr,
        output intDisable, intEnable, clrPend, eoi,
        input  intPending, intVector, isrAddr,
        input  inService, pendBits, maskBits
    );

    modport slave (
        input  irqIn, maskIn, MASKld, MASKclr,
        input  intDisable, intEnable, clrPend, eoi,
        output intPending, intVector, isrAddr,
        output inService, pendBits, maskBits
    );
endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// A rise sampled at edge E gives a one-cycle pulse after edge E+2.
module irq_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic i_irq,
    output logic o_pulse
);
    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_irq;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_pulse <= r_s2 & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/interrupt_controller.sv
// Pending/mask/enable interrupt controller feeding the sequencer
// a single request plus the vector and ISR entry address.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                VEC_W      = 3,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] ISR_BASE   = ADDR_W'(DEF_ISR_BASE),
    parameter int                ISR_STRIDE = DEF_ISR_STRIDE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    interrupt_controller_if.slave intc
);
    localparam int SHIFT = $clog2(ISR_STRIDE);

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_clr;
    logic [VEC_W-1:0]   w_top;
    logic               w_ack;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_en;
    logic [VEC_W-1:0]   r_vec;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_req;
    logic               r_svc;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_irq   (intc.irqIn[g]),
            .o_pulse (w_edge[g])
        );
    end

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic [VEC_W-1:0] v
    );
        addr_of = ISR_BASE + (ADDR_W'(v) << SHIFT);
    endfunction

    assign w_elig = r_pend & r_mask;
    assign w_top  = VEC_W'(prio_enc(MAX_IRQ'(w_elig)));
    assign w_ack  = (r_state == REQ) && intc.clrPend;
    assign w_clr  = w_ack ? (NUM_IRQ'(1) << r_vec) : '0;

    // New edge is OR-ed after the clear so a coincident event survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            r_mask <= '0;
            r_en   <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
            if (intc.MASKclr)     r_mask <= '0;
            else if (intc.MASKld) r_mask <= intc.maskIn;
            if (intc.intDisable)     r_en <= 1'b0;
            else if (intc.intEnable) r_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_addr  <= ISR_BASE;
            r_req   <= 1'b0;
            r_svc   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_en && (w_elig != '0)) begin
                        r_state <= REQ;
                        r_vec   <= w_top;
                        r_addr  <= addr_of(w_top);
                        r_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (intc.clrPend) begin
                        r_state <= SERVICE;
                        r_req   <= 1'b0;
                        r_svc   <= 1'b1;
                    end else if (!r_en || !w_elig[r_vec]) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (intc.eoi) begin
                        r_state <= IDLE;
                        r_svc   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_svc   <= 1'b0;
                end
            endcase
        end
    end

    assign intc.intPending = r_req;
    assign intc.intVector  = r_vec;
    assign intc.isrAddr    = r_addr;
    assign intc.inService  = r_svc;
    assign intc.pendBits   = r_pend;
    assign intc.maskBits   = r_mask;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the interrupt controller.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   run_cmp = 1'b0;

    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_IRQ(8), .VEC_W(3), .ADDR_W(16)) intc ();

    interrupt_controller #(
        .NUM_IRQ(8), .VEC_W(3), .ADDR_W(16),
        .ISR_BASE(16'h0040), .ISR_STRIDE(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .intc    (intc)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples delayed by 3 edges, then the
    // request/service rules applied to the pre-edge register values.
    logic [7:0]  hist [4];
    logic [7:0]  m_pend, m_mask, ne, elig, clr;
    bit          m_en, m_req, m_svc;
    int          m_ph;
    int          m_vec;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) hist[i] = '0;
            m_pend = '0; m_mask = '0; m_en = 0;
            m_req = 0; m_svc = 0; m_ph = 0; m_vec = 0;
        end else begin
            ne   = hist[2] & ~hist[3];
            elig = m_pend & m_mask;
            clr  = '0;
            if (m_ph == 0) begin
                if (m_en && elig != 0) begin
                    for (int i = 7; i >= 0; i--) if (elig[i]) m_vec = i;
                    m_ph = 1; m_req = 1;
                end
            end else if (m_ph == 1) begin
                if (intc.clrPend) begin
                    clr[m_vec] = 1'b1;
                    m_ph = 2; m_req = 0; m_svc = 1;
                end else if (!m_en || !elig[m_vec]) begin
                    m_ph = 0; m_req = 0;
                end
            end else if (intc.eoi) begin
                m_ph = 0; m_svc = 0;
            end
            m_pend = (m_pend & ~clr) | ne;
            if (intc.MASKclr) m_mask = '0;
            else if (intc.MASKld) m_mask = intc.maskIn;
            if (intc.intDisable) m_en = 0;
            else if (intc.intEnable) m_en = 1;
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = intc.irqIn;
        end
    end

    always @(negedge clk) begin
        if (reset_n && run_cmp) begin
            chk("m_intPending", intc.intPending, m_req);
            chk("m_intVector", intc.intVector, m_vec);
            chk("m_isrAddr", intc.isrAddr, 16'h0040 + m_vec * 4);
            chk("m_inService", intc.inService, m_svc);
            chk("m_pendBits", intc.pendBits, m_pend);
            chk("m_maskBits", intc.maskBits, m_mask);
        end
    end

    task automatic ctl_idle();
        intc.MASKld = 0; intc.MASKclr = 0; intc.intDisable = 0;
        intc.intEnable = 0; intc.clrPend = 0; intc.eoi = 0;
    endtask

    task automatic wait_pend(input logic want, input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (intc.intPending === want) break;
        end
        chk(name, intc.intPending, want);
    endtask

    task automatic pulse_clr();
        @(negedge clk) intc.clrPend = 1;
        @(negedge clk) intc.clrPend = 0;
    endtask

    task automatic pulse_eoi();
        @(negedge clk) intc.eoi = 1;
        @(negedge clk) intc.eoi = 0;
    endtask

    task automatic load_mask(input logic [7:0] m);
        @(negedge clk) begin intc.MASKld = 1; intc.maskIn = m; end
        @(negedge clk) intc.MASKld = 0;
    endtask

    initial begin
        intc.irqIn = '0; intc.maskIn = '0; ctl_idle();
        #12;
        chk("rst_intPending", intc.intPending, 1'b0);
        chk("rst_intVector", intc.intVector, 3'd0);
        chk("rst_isrAddr", intc.isrAddr, 16'h0040);
        chk("rst_inService", intc.inService, 1'b0);
        chk("rst_pendBits", intc.pendBits, 8'h00);
        chk("rst_maskBits", intc.maskBits, 8'h00);
        @(negedge clk) reset_n = 1;
        run_cmp = 1;

        // Line 5: pend at E+3, request at E+4
        @(negedge clk) begin
            intc.MASKld = 1; intc.maskIn = 8'hFF; intc.intEnable = 1;
        end
        @(negedge clk) ctl_idle();
        @(negedge clk) intc.irqIn[5] = 1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 chk("t1_pend_E2", intc.pendBits, 8'h00);
        @(posedge clk);
        #1 chk("t1_pend_E3", intc.pendBits, 8'h20);
        chk("t1_req_E3", intc.intPending, 1'b0);
        @(posedge clk);
        #1 chk("t1_req_E4", intc.intPending, 1'b1);
        chk("t1_vec", intc.intVector, 3'd5);
        chk("t1_addr", intc.isrAddr, 16'h0054);
        repeat (3) @(negedge clk);
        intc.irqIn[5] = 0;
        pulse_clr();
        chk("t1_svc", intc.inService, 1'b1);
        chk("t1_pend_clr", intc.pendBits, 8'h00);
        pulse_eoi();

        // Lines 6 and 2 together: lowest index first
        @(negedge clk) begin intc.irqIn[6] = 1; intc.irqIn[2] = 1; end
        wait_pend(1, "t2_req_a");
        chk("t2_vec_a", intc.intVector, 3'd2);
        intc.irqIn = '0;
        pulse_clr();
        chk("t2_pend", intc.pendBits, 8'h40);
        chk("t2_svc", intc.inService, 1'b1);
        pulse_eoi();
        wait_pend(1, "t2_req_b");
        chk("t2_vec_b", intc.intVector, 3'd6);
        chk("t2_addr_b", intc.isrAddr, 16'h0058);
        pulse_clr();
        pulse_eoi();

        // Masked line latches but does not request
        load_mask(8'h00);
        @(negedge clk) intc.irqIn[1] = 1;
        repeat (6) @(negedge clk);
        intc.irqIn[1] = 0;
        chk("t3_pend", intc.pendBits, 8'h02);
        chk("t3_noreq", intc.intPending, 1'b0);
        @(negedge clk) begin intc.MASKld = 1; intc.maskIn = 8'h02; end
        @(negedge clk) intc.MASKld = 0;
        chk("t3_req_early", intc.intPending, 1'b0);
        @(negedge clk);
        chk("t3_req", intc.intPending, 1'b1);
        pulse_clr();
        pulse_eoi();
        load_mask(8'hFF);

        // Disable while requesting
        @(negedge clk) intc.irqIn[3] = 1;
        wait_pend(1, "t4_req");
        chk("t4_vec", intc.intVector, 3'd3);
        intc.irqIn[3] = 0;
        @(negedge clk) intc.intDisable = 1;
        @(negedge clk) intc.intDisable = 0;
        wait_pend(0, "t4_drop");
        chk("t4_pend_kept", intc.pendBits[3], 1'b1);
        @(negedge clk) intc.intEnable = 1;
        @(negedge clk) intc.intEnable = 0;
        wait_pend(1, "t4_rereq");
        chk("t4_vec2", intc.intVector, 3'd3);
        pulse_clr();
        pulse_eoi();

        // Ack coincident with a new edge on the same line
        @(negedge clk) intc.irqIn[4] = 1;
        wait_pend(1, "t5_req");
        chk("t5_vec", intc.intVector, 3'd4);
        intc.irqIn[4] = 0;
        @(negedge clk) intc.irqIn[4] = 1;
        repeat (3) @(negedge clk);
        intc.clrPend = 1;
        @(negedge clk) begin intc.clrPend = 0; intc.irqIn[4] = 0; end
        chk("t5_pend_kept", intc.pendBits[4], 1'b1);
        chk("t5_svc", intc.inService, 1'b1);
        pulse_eoi();
        wait_pend(1, "t5_req2");
        chk("t5_vec2", intc.intVector, 3'd4);
        pulse_clr();
        chk("t6_in_svc", intc.inService, 1'b1);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("t6_intPending", intc.intPending, 1'b0);
        chk("t6_intVector", intc.intVector, 3'd0);
        chk("t6_isrAddr", intc.isrAddr, 16'h0040);
        chk("t6_inService", intc.inService, 1'b0);
        chk("t6_pendBits", intc.pendBits, 8'h00);
        chk("t6_maskBits", intc.maskBits, 8'h00);
        @(negedge clk) reset_n = 1;
        load_mask(8'hFF);
        @(negedge clk) intc.intEnable = 1;
        @(negedge clk) intc.intEnable = 0;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 0;
                @(negedge clk) reset_n = 1;
            end
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) intc.irqIn[i] = ~intc.irqIn[i];
            intc.maskIn     = 8'($urandom);
            intc.MASKld     = ($urandom_range(0, 19) == 0);
            intc.MASKclr    = ($urandom_range(0, 59) == 0);
            intc.intDisable = ($urandom_range(0, 29) == 0);
            intc.intEnable  = ($urandom_range(0, 7) == 0);
            intc.clrPend    = ($urandom_range(0, 2) == 0);
            intc.eoi        = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk) ctl_idle();
        @(negedge clk);
        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects external interrupt lines, latches them as pending events, and applies the mask register and the global enable.
- Drives the single intPending request into the multi-cycle controller sequencer.
- Takes the sequencer's MASKld/MASKclr, intDisable and clrPend strobes back as control.
- Supplies the serviced vector number and ISR entry address, which the PC loads during the subroutine/interrupt entry sequence.

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (2..16)
- VEC_W, 3, vector index width; must equal ceil(log2(NUM_IRQ))
- ADDR_W, 16, ISR address width
- ISR_BASE, 16'h0040, address of the vector-0 handler
- ISR_STRIDE, 4, address distance between consecutive handlers (power of two)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- irqIn  in  NUM_IRQ  external interrupt lines, asynchronous, active-high, edge-triggered
- maskIn  in  NUM_IRQ  mask value from data path; 1 = line enabled
- MASKld  in  1  load maskIn into the mask register
- MASKclr  in  1  clear the mask register (all lines disabled)
- intDisable  in  1  clear the global enable
- intEnable  in  1  set the global enable (issued on return from ISR)
- clrPend  in  1  acknowledge from sequencer; consumes the current request
- eoi  in  1  end of interrupt; handler finished
- intPending  out  1  registered request to the sequencer
- intVector  out  VEC_W  vector being requested or serviced
- isrAddr  out  ADDR_W  ISR_BASE + intVector*ISR_STRIDE, truncated to ADDR_W
- inService  out  1  high while a handler is running
- pendBits  out  NUM_IRQ  raw pending register, for status reads
- maskBits  out  NUM_IRQ  mask register, for status reads

Behaviour:
- Reset (async, reset_n=0):
  - Synchronizers, edge history, pend, mask and curVec clear to 0.
  - Global enable = 0; state = IDLE.
  - Outputs: intPending=0, intVector=0, isrAddr=ISR_BASE, inService=0, pendBits=0, maskBits=0.
  - Reset mid-request or mid-service abandons the operation with no residue.
- Input path, per line:
  - Two-flop synchronizer, then rising-edge detect (sync=1 and previous=0).
  - A rising edge sampled at edge E sets pend[i] at edge E+3.
  - A level held high produces exactly one event.
- Pend clear and set:
  - pend[curVec] clears on the edge where clrPend is sampled in REQ.
  - A new edge on that same line in the same cycle: set wins, the event is retained.
- Mask register:
  - MASKld loads maskIn. MASKclr clears. Both in the same cycle: clear wins.
  - Masked lines still latch pend; they are just not eligible.
- Global enable:
  - intEnable sets it; intDisable clears it. Both in the same cycle: disable wins.
- Eligibility:
  - elig = pend & mask.
  - Priority = lowest index wins (fixed priority encoder).
- State machine: IDLE, REQ, SERVICE (encoding in package).
  - IDLE: if enable=1 and elig!=0, go to REQ and latch the encoder result into curVec on that edge.
    - intPending=1 from the same edge, so it is high 1 cycle after the pend bit is set while idle.
  - REQ: intPending=1; intVector=curVec, held stable (no preemption by a higher-priority arrival).
    - clrPend: go to SERVICE; intPending=0 from that edge.
    - Else if enable=0 or elig[curVec]=0 (masked/disabled before ack): go to IDLE, intPending=0, pend untouched.
  - SERVICE: inService=1, intPending=0; no new request while in SERVICE.
    - eoi: go to IDLE. The next eligible request may assert intPending 1 cycle later if enable=1.
  - eoi outside SERVICE, or clrPend outside REQ: ignored.
- isrAddr is registered alongside curVec. The stride multiply is a shift; wrap modulo 2^ADDR_W.

Decomposition:
- Package intc_pkg holds:
  - State enum (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2).
  - Default ISR_BASE/ISR_STRIDE constants.
  - A priority-encoder function returning VEC_W bits.
- One sub-module, irq_sync_edge: 2-flop synchronizer plus rising-edge pulse, clk/reset_n, 1-bit in, 1-bit pulse out. It is instantiated NUM_IRQ times via generate.

Test Plan:
- Reset then MASKld maskIn=8'hFF, intEnable; pulse irqIn[5] at edge 10 -> pendBits[5]=1 at edge 13, intPending=1 at edge 14, intVector=5, isrAddr=16'h0054.
- irqIn[6] and irqIn[2] rising in the same cycle -> intVector=2. clrPend -> pend=8'h40, inService=1. eoi -> next request intVector=6, isrAddr=16'h0058.
- mask=8'h00, pulse irqIn[1] -> pendBits=8'h02, intPending stays 0. Then MASKld 8'h02 -> intPending=1 one cycle later.
- In REQ with vector 3, assert intDisable -> returns to IDLE, intPending=0, pendBits[3] still 1. intEnable -> intPending re-asserts with vector 3.
- clrPend on vector 4 coincident with a new edge on line 4 -> pendBits[4] remains 1. After eoi a second request for vector 4 is issued.
- Drive reset_n low mid-SERVICE, between clock edges -> all outputs return to reset values immediately, without waiting for a clock edge.
